// File: rtl/bloom_port_arbiter_pkg.sv
// Shared definitions for the Bloom filter bit-array port arbiter:
// source encodings and the output-register state encoding.
package bloom_arb_defs;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/bloom_port_arbiter_if.sv
// Handshake bundle between the hash stages, the arbiter and the bit-array controller.
// master = requesters plus downstream (the surrounding logic), slave = the arbiter.
interface bloom_port_arbiter_if #(
    parameter int N = 32
);
    logic         a_valid;
    logic [N-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [N-1:0] b_data;
    logic         b_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_n.sv
// Generic two-input N-bit mux shared across the Bloom filter datapath (sel = 1 picks a).
module mux_n #(
    parameter int n = 32
) (
    input  logic         sel,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y
);
    assign y = sel ? a : b;
endmodule

// File: rtl/bloom_port_arbiter.sv
// Round-robin arbiter sharing the bit-array port between insert (A) and query (B).
// Optional per-requester wait counters are enabled with BLOOM_ARB_WAIT_CNT_EN.
module bloom_port_arbiter
    import bloom_arb_defs::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    bloom_port_arbiter_if.slave bus
`ifdef BLOOM_ARB_WAIT_CNT_EN
    ,
    output logic [CNT_W-1:0] a_wait_cnt,
    output logic [CNT_W-1:0] b_wait_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    out_state_e   r_state;
    logic         r_last_grant;
    logic [N-1:0] r_out_data;
    logic         r_out_src;

    logic         w_grant_a;
    logic         w_grant_b;
    logic         w_can_accept;
    logic         w_accept;
    logic         w_drain;
    logic [N-1:0] w_mux_y;

    assign w_grant_a = bus.a_valid & (~bus.b_valid | (r_last_grant == SRC_B));
    assign w_grant_b = bus.b_valid & ~w_grant_a;

    // Gating with rst_n keeps any handshake from completing while reset is held.
    assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | bus.out_ready);
    assign w_accept     = w_can_accept & (w_grant_a | w_grant_b);
    assign w_drain      = (r_state == ST_FULL) & bus.out_ready;

    assign bus.a_ready   = w_can_accept & w_grant_a;
    assign bus.b_ready   = w_can_accept & w_grant_b;
    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;

    mux_n #(.n(N)) u_mux (
        .sel (w_grant_a),
        .a   (bus.a_data),
        .b   (bus.b_data),
        .y   (w_mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_out_data   <= '0;
            r_out_src    <= SRC_B;
            r_last_grant <= SRC_B;
        end else begin
            if (w_accept) begin
                r_state      <= ST_FULL;
                r_out_data   <= w_mux_y;
                r_out_src    <= w_grant_a ? SRC_A : SRC_B;
                r_last_grant <= w_grant_a ? SRC_A : SRC_B;
            end else if (w_drain) begin
                r_state <= ST_EMPTY;
            end
        end
    end

`ifdef BLOOM_ARB_WAIT_CNT_EN
    logic [CNT_W-1:0] r_a_wait;
    logic [CNT_W-1:0] r_b_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_wait <= '0;
            r_b_wait <= '0;
        end else begin
            if (bus.a_valid & bus.a_ready) begin
                r_a_wait <= '0;
            end else if (bus.a_valid && (r_a_wait != {CNT_W{1'b1}})) begin
                r_a_wait <= r_a_wait + 1'b1;
            end
            if (bus.b_valid & bus.b_ready) begin
                r_b_wait <= '0;
            end else if (bus.b_valid && (r_b_wait != {CNT_W{1'b1}})) begin
                r_b_wait <= r_b_wait + 1'b1;
            end
        end
    end

    assign a_wait_cnt = r_a_wait;
    assign b_wait_cnt = r_b_wait;
`endif

endmodule

// File: tb/tb_bloom_port_arbiter.sv
// Scoreboard bench for bloom_port_arbiter: the driver pushes expected grants, a
// negedge monitor pops and compares whenever the output register is drained.
module tb_bloom_port_arbiter;
    localparam int N     = 32;
    localparam int CNT_W = 2;

    typedef struct {
        logic         src;
        logic [N-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bloom_port_arbiter_if #(.N(N)) bus ();

`ifdef BLOOM_ARB_WAIT_CNT_EN
    logic [CNT_W-1:0] a_wait_cnt;
    logic [CNT_W-1:0] b_wait_cnt;
`endif

    bloom_port_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef BLOOM_ARB_WAIT_CNT_EN
        ,
        .a_wait_cnt (a_wait_cnt),
        .b_wait_cnt (b_wait_cnt)
`endif
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic             m_full = 1'b0;
    logic             m_last = 1'b0;
    logic [CNT_W-1:0] m_wa = '0;
    logic [CNT_W-1:0] m_wb = '0;

    localparam logic [N-1:0] DA  = 32'hAAAA0001;
    localparam logic [N-1:0] DB  = 32'hBBBB0002;
    localparam logic [N-1:0] Z   = 32'h0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // One clock of stimulus; compares handshake outputs against the model at negedge.
    task automatic step(input logic av, input logic [N-1:0] ad,
                        input logic bv, input logic [N-1:0] bd, input logic ordy);
        logic can, ga, gb;
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.out_ready = ordy;
        @(negedge clk);
        can = rst_n && (!m_full || ordy);
        ga  = av && (!bv || !m_last);
        gb  = bv && !ga;
        check("a_ready", {31'b0, bus.a_ready}, {31'b0, can && ga});
        check("b_ready", {31'b0, bus.b_ready}, {31'b0, can && gb});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_full});
`ifdef BLOOM_ARB_WAIT_CNT_EN
        check("a_wait_cnt", {30'b0, a_wait_cnt}, {30'b0, m_wa});
        check("b_wait_cnt", {30'b0, b_wait_cnt}, {30'b0, m_wb});
`endif
        if (can && ga) sb_q.push_back('{1'b1, ad});
        if (can && gb) sb_q.push_back('{1'b0, bd});
        if (!rst_n) begin
            m_full = 1'b0;
            m_last = 1'b0;
            m_wa   = '0;
            m_wb   = '0;
        end else begin
            if (can && (ga || gb)) begin
                m_full = 1'b1;
                m_last = ga;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
            if (av) m_wa = (can && ga) ? '0 : sat_inc(m_wa);
            if (bv) m_wb = (can && gb) ? '0 : sat_inc(m_wb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m_full = 1'b0;
        m_last = 1'b0;
        m_wa   = '0;
        m_wb   = '0;
        sb_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty at %0t: got out_valid with data %h, expected no pending item",
                         $time, bus.out_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_src", {31'b0, bus.out_src}, {31'b0, e.src});
                check("out_data", bus.out_data, e.data);
            end
        end
    end

    initial begin
        bus.a_valid = 1'b0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_data = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;

        // Both requesting while in reset: nothing may be granted
        repeat (3) step(1'b1, DA, 1'b1, DB, 1'b1);
        rst_n = 1'b1;

        // Sustained contention: A first, then strict alternation
        repeat (6) step(1'b1, DA, 1'b1, DB, 1'b1);
        step(1'b0, Z, 1'b0, Z, 1'b1);

        // Only B valid with last grant = B
        step(1'b0, Z, 1'b1, 32'h0000B0B0, 1'b1);

        // Stall with both valid; priority must not rotate
        repeat (4) step(1'b1, 32'h11110003, 1'b1, 32'h22220004, 1'b0);
        step(1'b1, 32'h11110003, 1'b1, 32'h22220004, 1'b1);
        step(1'b0, Z, 1'b1, 32'h22220004, 1'b1);
        step(1'b1, 32'h33330005, 1'b0, Z, 1'b1);
        step(1'b1, 32'h44440006, 1'b0, Z, 1'b1);
        step(1'b0, Z, 1'b0, Z, 1'b1);

        // Reset while holding a request discards it
        step(1'b1, 32'h55550007, 1'b0, Z, 1'b0);
        step(1'b0, Z, 1'b0, Z, 1'b0);
        do_reset();
        step(1'b1, 32'h66660008, 1'b1, 32'h77770009, 1'b1);
        rst_n = 1'b1;
        step(1'b0, Z, 1'b1, 32'h8888000A, 1'b1);
        step(1'b0, Z, 1'b0, Z, 1'b1);

        // Blocked requesters accumulate wait (saturating counters when enabled)
        step(1'b1, 32'h9999000B, 1'b0, Z, 1'b1);
        repeat (5) step(1'b1, 32'hCCCC000C, 1'b1, 32'hDDDD000D, 1'b0);
        step(1'b1, 32'hCCCC000C, 1'b1, 32'hDDDD000D, 1'b1);
        step(1'b1, 32'hCCCC000C, 1'b0, Z, 1'b1);
        repeat (2) step(1'b0, Z, 1'b0, Z, 1'b1);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending items, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bloom_port_arbiter.md
Name: bloom_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one bit-array access port between the insert path (requester A) and the query path (requester B) of the Bloom filter.
- Each requester uses a valid/ready handshake.
- The winning request is selected through an existing mux_n instance and captured in a one-entry output register that drives the shared port.
- Sits between the hash stages and the bit-array controller.

Parameters:
- N, 32, request payload width in bits (hash index plus op bits).
- CNT_W, 8, wait-counter width; used only with BLOOM_ARB_WAIT_CNT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A (insert) has a request.
- a_data  input  N  requester A payload.
- a_ready  output  1  A's request is accepted this cycle.
- b_valid  input  1  requester B (query) has a request.
- b_data  input  N  requester B payload.
- b_ready  output  1  B's request is accepted this cycle.
- out_valid  output  1  output register holds a request.
- out_data  output  N  registered payload.
- out_src  output  1  source of out_data: 1 = A, 0 = B (same sense as mux_n sel).
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset is asynchronous and active-low:
  - out_valid = 0, out_data = 0, out_src = 0.
  - last_grant = B, so A wins the first contention.
  - Wait counters = 0.
- Output register FSM has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain (out_valid & out_ready) with no new accept.
  - FULL → FULL on simultaneous drain and accept.
- can_accept = EMPTY | (out_ready in FULL). Pass-through on drain is required; no bubble.
- Grant logic (combinational):
  - grant_a = a_valid & (~b_valid | last_grant == B).
  - grant_b = b_valid & ~grant_a.
- Ready outputs:
  - a_ready = can_accept & grant_a; b_ready = can_accept & grant_b.
  - Never both high in the same cycle.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- On accept:
  - out_data ← mux_n(sel = grant_a, a = a_data, b = b_data).
  - out_src ← grant_a.
  - last_grant ← winner.
  - Latency: accepted at edge t, presented from t+1.
- last_grant updates only on an actual accept. Contention while stalled (FULL & ~out_ready) does not rotate priority.
- Single requester valid: it is granted regardless of last_grant.
- Under sustained contention with out_ready = 1, grants strictly alternate A, B, A, B, ...
- Requester valid/data must stay stable until its ready. out_data and out_src stay stable while out_valid & ~out_ready.
- Reset asserted mid-transfer discards the held request immediately; no handshake completes in that cycle.

Optional Feature:
- Macro: BLOOM_ARB_WAIT_CNT_EN.
- Defined:
  - Adds outputs a_wait_cnt and b_wait_cnt, each CNT_W bits.
  - Each counter increments every cycle its requester has valid & ~ready.
  - Saturates at 2^CNT_W−1.
  - Clears to 0 in the cycle after that requester's handshake.
  - Reset value 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/include bloom_arb_defs holds:
  - SRC_A = 1'b1, SRC_B = 1'b0.
  - Output FSM encoding: ST_EMPTY = 1'b0, ST_FULL = 1'b1.
- Data selection reuses the existing mux_n (#(.n(N))). No new sub-module.
- Grant, FSM and counters live in the top-level module.

Test Plan:
- Reset with a_valid = b_valid = 1 → out_valid = 0, no ready. Release reset → a_ready = 1 first cycle; next cycle out_src = 1, out_data = a_data.
- Contention, N = 32, a_data = 0xAAAA0001, b_data = 0xBBBB0002, out_ready = 1 for 6 cycles → out_src sequence 1,0,1,0,1,0; no idle cycles after the first.
- Only B valid, last_grant = B → b_ready = 1; out_src = 0, out_data = b_data one cycle later.
- Stall: out_ready = 0 for 4 cycles with both valid, out_valid = 1 → a_ready = b_ready = 0; out_data held; last_grant unchanged. Release → the non-last requester wins.
- Drain and accept in the same cycle (FULL, out_ready = 1, a_valid = 1) → a_ready = 1; out_valid stays 1; out_data updates next edge.
- With BLOOM_ARB_WAIT_CNT_EN, CNT_W = 2, B blocked 5 cycles → b_wait_cnt = 1,2,3,3,3; returns to 0 the cycle after b handshake.
